// File: rtl/sar_controlador_dms.sv
// sar_controlador_dms: successive-approximation sequencer for comparador_dms.
// Define SAR_CMP_SYNC_EN to pass cmp_i through a two-flop synchronizer (adds two settle cycles per bit).
module sar_controlador_dms #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cmp_i,
    output logic              sample_o,
    output logic [N_BITS-1:0] dac_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_BITS-1:0] data_o
);
`ifdef SAR_CMP_SYNC_EN
    localparam int SYNC_LAT = 2;
    logic [1:0] cmp_sync;
    logic       cmp_eff;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cmp_sync <= '0;
        else       cmp_sync <= {cmp_sync[0], cmp_i};
    assign cmp_eff = cmp_sync[1];
`else
    localparam int SYNC_LAT = 0;
    logic cmp_eff;
    assign cmp_eff = cmp_i;
`endif
    localparam int CNT_MAX = (SAMPLE_CYCLES - 1 > SETTLE_CYCLES - 1 + SYNC_LAT) ?
                             SAMPLE_CYCLES - 1 : SETTLE_CYCLES - 1 + SYNC_LAT;
    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IDX_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1 + SYNC_LAT);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N_BITS - 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} state_t;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [N_BITS-1:0] dac, dac_n, data, data_n;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            dac   <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            dac   <= dac_n;
            data  <= data_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        dac_n   = dac;
        data_n  = data;
        case (state)
            IDLE:
                if (start_i) begin
                    state_n = SAMPLE;
                    cnt_n   = SAMPLE_LD;
                end
            SAMPLE:
                if (cnt == '0) begin
                    state_n = SETTLE;
                    dac_n   = {1'b1, {(N_BITS-1){1'b0}}};
                    idx_n   = IDX_TOP;
                    cnt_n   = SETTLE_LD;
                end else cnt_n = cnt - CNT_W'(1);
            SETTLE:
                if (cnt == '0) state_n = DECIDE;
                else           cnt_n   = cnt - CNT_W'(1);
            DECIDE: begin
                dac_n[idx] = cmp_eff;
                if (idx == '0) begin
                    state_n = DONE;
                    data_n  = dac_n;
                end else begin
                    idx_n        = idx - IDX_W'(1);
                    dac_n[idx_n] = 1'b1;
                    cnt_n        = SETTLE_LD;
                    state_n      = SETTLE;
                end
            end
            DONE: begin
                state_n = IDLE;
                dac_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign sample_o = (state == SAMPLE);
    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);
    assign dac_o    = dac;
    assign data_o   = data;
endmodule

// File: tb/tb_sar_controlador_dms.sv
// tb_sar_controlador_dms: directed and random conversions against an ideal-comparator SAR model.
module tb_sar_controlador_dms;
`ifdef SAR_CMP_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int N   = 8;
    localparam int S   = 2;
    localparam int T   = 2 + SYNC_LAT;
    localparam int LAT = S + N * (T + 1) + 1;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cmp;
    logic       sample, busy, done;
    logic [7:0] dac, data;
    real        vin = 0.0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;
    always_comb cmp = vin > real'(dac) / 256.0;

    sar_controlador_dms dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cmp_i(cmp),
        .sample_o(sample), .dac_o(dac), .busy_o(busy), .done_o(done), .data_o(data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ideal SAR result: the largest code whose DAC level lies strictly below vin.
    function automatic logic [7:0] sar_ref(input real v);
        int best = 0;
        for (int c = 0; c < 256; c++) if (real'(c) / 256.0 < v) best = c;
        return 8'(best);
    endfunction

    // Trial code k: result bits already decided above position 7-k, plus the bit under test.
    function automatic logic [7:0] trial(input logic [7:0] r, input int k);
        logic [7:0] hi;
        hi = (k == 0) ? 8'h00 : (8'hFF << (8 - k));
        return (r & hi) | (8'h80 >> k);
    endfunction

    task automatic convert(input real v, input int pulse_at, input int rst_at, output int ndone);
        logic [7:0] r;
        int k;
        r = sar_ref(v);
        vin = v;
        ndone = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
            @(negedge clk);
            if (cyc == rst_at) return;
            if (cyc == pulse_at) start = 1'b1;
            else if (cyc == pulse_at + 1) start = 1'b0;
            if (done) ndone++;
            check("busy", busy, cyc <= LAT);
            check("sample", sample, cyc <= S);
            check("done", done, cyc == LAT);
            if (cyc > S && cyc < LAT) begin
                k = (cyc - S - 1) / (T + 1);
                check("dac_trial", dac, trial(r, k));
            end
            if (cyc == LAT) begin
                check("dac_final", dac, r);
                check("data", data, r);
            end
            if (cyc == LAT + 1) check("dac_idle", dac, 0);
        end
    endtask

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        check("rst_sample", sample, 0);
        check("rst_dac", dac, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        rst = 1'b0;
        @(negedge clk);
        convert(0.50195, -1, -1, nd); check("ndone", nd, 1); check("data_80", data, 8'h80);
        convert(0.0, -1, -1, nd);     check("ndone", nd, 1); check("data_00", data, 8'h00);
        convert(1.0, -1, -1, nd);     check("ndone", nd, 1); check("data_ff", data, 8'hFF);
        convert(0.3, -1, -1, nd);     check("ndone", nd, 1); check("data_4c", data, 8'h4C);
        convert(0.5, -1, -1, nd);     check("data_7f", data, 8'h7F);
        convert(0.3, 5, -1, nd);      check("ndone_pulse", nd, 1);
        repeat (6) begin
            convert(real'($urandom_range(0, 1000)) / 1000.0, -1, -1, nd);
            check("ndone_rand", nd, 1);
        end
        convert(0.50195, -1, -1, nd); check("data_pre_rst", data, 8'h80);
        convert(0.7, -1, 10, nd);
        rst = 1'b1;
        #1;
        check("abort_sample", sample, 0);
        check("abort_dac", dac, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_data", data, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        convert(0.3, -1, -1, nd); check("ndone_after_rst", nd, 1); check("data_after_rst", data, 8'h4C);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
